// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Queue entries carry an instruction word and its byte PC.
package instruction_fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fq_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Circular prefetch buffer: up to two pushes and one pop per cycle.
// A synchronous flush empties it; reset is asynchronous.
module instruction_fetch_unit_fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  fq_entry_t     push0,
  input  fq_entry_t     push1,
  input  logic          pop,
  output fq_entry_t     head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free
);

  fq_entry_t     mem [QDEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic [PW-1:0] wr1;

  assign wr1  = wr + PW'(1);
  assign head = mem[rd];
  assign free = CW'(QDEPTH) - count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      wr    <= wr + PW'(push_n);
      rd    <= rd + PW'(pop);
      count <= count + CW'(push_n) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible while count > 0.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_n != 2'd0) mem[wr]  <= push0;
      if (push_n == 2'd2) mem[wr1] <= push1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, prefetches up to two words per cycle
// into a small queue and hands them to decode via valid/ready.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128,
  parameter int          QDEPTH     = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  input  logic [31:0] ImemLookAhead,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        ID_Ready,
  output logic        IF_Valid,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCPlus4,
  output logic        FetchDone
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] idx;
  logic              done;
  logic              pair_ok;
  logic [1:0]        push_n;
  logic              pop;
  fq_entry_t         push0;
  fq_entry_t         push1;
  fq_entry_t         head;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;

  assign idx         = {2'b00, pc[31:2]};
  assign ImemAddress = idx;
  assign done        = idx >= 32'(IMEM_WORDS);
  assign pair_ok     = idx <= 32'(IMEM_WORDS - 2);
  assign FetchDone   = done;

  assign push0 = '{instr: ImemInstruction, pc: pc};
  assign push1 = '{instr: ImemLookAhead, pc: pc + 32'd4};

  // A redirect flushes the head, so it must not also count as a pop.
  assign pop = IF_Valid && ID_Ready && !Redirect;

  always_comb begin
    push_n  = 2'd0;
    pc_next = pc;
    if (Redirect) begin
      pc_next = RedirectPC & ~32'h3;
    end else if (!done) begin
      if (free >= CW'(2) && pair_ok) begin
        push_n  = 2'd2;
        pc_next = pc + 32'd8;
      end else if (free >= CW'(1)) begin
        push_n  = 2'd1;
        pc_next = pc + 32'd4;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pc <= RESET_PC & ~32'h3;
    else       pc <= pc_next;
  end

  instruction_fetch_unit_fetch_queue #(.QDEPTH(QDEPTH)) u_fq (
    .clk    (Clk),
    .rst    (Reset),
    .flush  (Redirect),
    .push_n (push_n),
    .push0  (push0),
    .push1  (push1),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .free   (free)
  );

  assign IF_Valid       = count != '0;
  assign IF_Instruction = IF_Valid ? head.instr : NOP;
  assign IF_PC          = IF_Valid ? head.pc : '0;
  assign IF_PCPlus4     = IF_Valid ? head.pc + 32'd4 : '0;

endmodule
